// File: rtl/ifq_pkg.sv
// ----------------------------------------------------------------------------
// ifq_pkg
//   Shared types and constants for the instruction fetch queue.
//   - ifq_entry_t : one buffered fetch result {pc, instr} at the default
//                   32-bit widths. It is also the default element type of
//                   ifq_fifo.
//   - PC_STEP     : byte distance between sequential fetch addresses.
//   - ifq_cnt_w() : width of a counter that must hold 0..depth inclusive.
// ----------------------------------------------------------------------------
package ifq_pkg;

  localparam int IFQ_DATA_W = 32;
  localparam int IFQ_ADDR_W = 32;
  localparam int PC_STEP    = 4;

  typedef struct packed {
    logic [IFQ_ADDR_W-1:0] pc;
    logic [IFQ_DATA_W-1:0] instr;
  } ifq_entry_t;

  function automatic int ifq_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// ----------------------------------------------------------------------------
// ifq_fifo
//   Synchronous FIFO of fetch entries. DEPTH must be a power of two, so the
//   read and write pointers wrap naturally. clear empties the FIFO and takes
//   priority over push and pop in the same cycle. The storage array is not
//   reset; only the pointers and the occupancy count are.
// Ports
//   clk        in   clock
//   nrst       in   synchronous active-low reset
//   clear      in   drop every entry (a same-cycle push or pop is ignored)
//   push       in   write push_entry at the tail
//   push_entry in   entry to write
//   pop        in   remove the head entry (caller guarantees count != 0)
//   head       out  current head entry (meaningful only when count != 0)
//   count      out  number of valid entries, 0..DEPTH
// ----------------------------------------------------------------------------
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter int  CNT_W   = ifq_cnt_w(DEPTH),
  parameter type entry_t = ifq_entry_t
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clear,
  input  logic             push,
  input  entry_t           push_entry,
  input  logic             pop,
  output entry_t           head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// ----------------------------------------------------------------------------
// instr_fetch_queue
//   Prefetch queue between instruction memory and the core. It issues
//   sequential, in-order fetch requests while credit allows
//   (buffered + outstanding < DEPTH), buffers the returned words together with
//   their PCs, and hands them to the core over a valid/ready handshake.
//   A redirect flushes the queue, restarts fetch at redirect_pc and marks
//   every in-flight request as stale so that its response is discarded.
// Parameters
//   DATA_W    instruction width
//   ADDR_W    PC / address width
//   DEPTH     queue entries, power of two, >= 2
//   RESET_PC  fetch PC after reset
// Ports
//   clk, nrst               clock, synchronous active-low reset
//   req_valid/addr/ready    fetch request to memory
//   rsp_valid/data          in-order response from memory
//   out_valid/instr/pc      queue head to core, out_ready consumes it
//   redirect/redirect_pc    flush and restart (redirect_pc[1:0] ignored)
// Optional build macro IFQ_STATS_EN
//   Adds saturating 32-bit counters stat_fetched, stat_flushes and
//   stat_dropped. Without the macro these ports do not exist.
// ----------------------------------------------------------------------------
module instr_fetch_queue
  import ifq_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              nrst,
  output logic              req_valid,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              req_ready,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              out_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef IFQ_STATS_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_flushes,
  output logic [31:0]       stat_dropped
`endif
);

  localparam int CNT_W = ifq_cnt_w(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic [CNT_W-1:0]  fifo_count;
  entry_t            fifo_head;
  entry_t            push_entry;
  logic [CNT_W:0]    in_use;
  logic              req_fire;
  logic              rsp_drop;
  logic              rsp_push;
  logic              pop;
  logic [ADDR_W-1:0] redirect_pc_aligned;

  // Credit: every queue slot is either holding a word or reserved by a
  // request still in flight (including stale ones that will be dropped).
  assign in_use    = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign req_valid = nrst && !redirect && (in_use < (CNT_W+1)'(DEPTH));
  assign req_addr  = fetch_pc_q;
  assign req_fire  = req_valid && req_ready;

  assign rsp_drop  = rsp_valid && (redirect || (drop_q != '0));
  assign rsp_push  = rsp_valid && !rsp_drop;

  assign out_valid = (fifo_count != '0);
  assign out_instr = out_valid ? fifo_head.instr : '0;
  assign out_pc    = out_valid ? fifo_head.pc    : '0;
  assign pop       = out_valid && out_ready && !redirect;

  assign push_entry          = '{pc: rsp_pc_q, instr: rsp_data};
  assign redirect_pc_aligned = redirect_pc & ~ADDR_W'(3);

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_valid);
    drop_d        = drop_q - CNT_W'(rsp_valid && (drop_q != '0));
    if (redirect) begin
      fetch_pc_d = redirect_pc_aligned;
      rsp_pc_d   = redirect_pc_aligned;
      // drop is always a subset of outstanding, so after a flush every
      // request still in flight (minus the one answered now) is stale.
      // This also keeps back-to-back redirects from double counting.
      drop_d     = outstanding_q - CNT_W'(rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
      if (rsp_push) rsp_pc_d   = rsp_pc_q   + ADDR_W'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  ifq_fifo #(
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W),
    .entry_t (entry_t)
  ) u_fifo (
    .clk        (clk),
    .nrst       (nrst),
    .clear      (redirect),
    .push       (rsp_push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (fifo_head),
    .count      (fifo_count)
  );

  // Memory may only answer requests it has actually accepted.
  assert property (@(posedge clk) disable iff (!nrst)
                   rsp_valid |-> (outstanding_q != '0));

`ifdef IFQ_STATS_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] flushes_q, flushes_d;
  logic [31:0] dropped_q, dropped_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

  always_comb begin
    fetched_d = sat_inc(fetched_q, req_fire);
    flushes_d = sat_inc(flushes_q, redirect);
    dropped_d = sat_inc(dropped_q, rsp_drop);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      fetched_q <= '0;
      flushes_q <= '0;
      dropped_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      flushes_q <= flushes_d;
      dropped_q <= dropped_d;
    end
  end

  assign stat_fetched = fetched_q;
  assign stat_flushes = flushes_q;
  assign stat_dropped = dropped_q;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_queue
//   Self-checking bench for instr_fetch_queue. A behavioural model keeps the
//   queue contents and the list of in-flight requests (with a stale flag set
//   by redirects) as SystemVerilog queues; a memory model answers accepted
//   requests in order after a programmable latency. A directed vector table,
//   a few hand-written multi-cycle sequences and a randomized run are all
//   compared against that model. Build with IFQ_STATS_EN to also check the
//   statistics counters.
// ----------------------------------------------------------------------------
module tb_instr_fetch_queue;

  localparam int          DATA_W   = 32;
  localparam int          ADDR_W   = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready = 1'b0;
  logic              rsp_valid = 1'b0;
  logic [DATA_W-1:0] rsp_data = '0;
  logic              out_valid;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              out_ready = 1'b0;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
`ifdef IFQ_STATS_EN
  logic [31:0] stat_fetched, stat_flushes, stat_dropped;
`endif

  always #5 clk = ~clk;

  instr_fetch_queue #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef IFQ_STATS_EN
    , .stat_fetched(stat_fetched), .stat_flushes(stat_flushes),
    .stat_dropped(stat_dropped)
`endif
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [31:0] pc; bit stale; } fl_t;
  typedef struct { logic [31:0] addr; int due; } mr_t;

  ent_t        mq[$];     // words buffered for the core
  fl_t         fq[$];     // requests accepted, response not yet seen
  mr_t         memq[$];   // memory side: pending responses
  logic [31:0] m_fpc;
  int          last_due;
  int          lat_base;
  int          lat_rand;
  int unsigned m_fetched, m_flushes, m_dropped;

  logic              obs_rv, obs_ov;
  logic [31:0]       obs_addr, obs_pc, obs_instr;

  task automatic model_clear();
    mq.delete();
    fq.delete();
    memq.delete();
    m_fpc     = RESET_PC;
    last_due  = -1;
    m_fetched = 0;
    m_flushes = 0;
    m_dropped = 0;
  endtask

  // One clock cycle: drive, observe before the edge, compare, update model.
  task automatic step(input logic redir, input logic [31:0] rpc,
                      input logic ordy, input logic rrdy);
    logic exp_rv, exp_ov;
    fl_t  fl;
    mr_t  mr;
    bit   drop_it;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = mem_word(memq[0].addr);
      void'(memq.pop_front());
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = $urandom;
    end
    redirect    = redir;
    redirect_pc = rpc;
    out_ready   = ordy;
    req_ready   = rrdy;
    #1;
    obs_rv = req_valid; obs_addr = req_addr;
    obs_ov = out_valid; obs_pc = out_pc; obs_instr = out_instr;

    exp_rv = !redir && ((mq.size() + fq.size()) < DEPTH);
    exp_ov = (mq.size() > 0);
    chk("req_valid", obs_rv, exp_rv);
    if (exp_rv) chk("req_addr", obs_addr, m_fpc);
    chk("out_valid", obs_ov, exp_ov);
    if (exp_ov) begin
      chk("out_pc", obs_pc, mq[0].pc);
      chk("out_instr", obs_instr, mq[0].instr);
    end else begin
      chk("out_pc_idle", obs_pc, 0);
      chk("out_instr_idle", obs_instr, 0);
    end
`ifdef IFQ_STATS_EN
    chk("stat_fetched", stat_fetched, m_fetched);
    chk("stat_flushes", stat_flushes, m_flushes);
    chk("stat_dropped", stat_dropped, m_dropped);
`endif

    if (exp_ov && ordy && !redir) void'(mq.pop_front());
    if (rsp_valid) begin
      if (fq.size() == 0) begin
        chk("rsp_tracking", 1, 0);
      end else begin
        fl = fq.pop_front();
        drop_it = fl.stale || redir;
        if (drop_it) m_dropped++;
        else mq.push_back('{pc: fl.pc, instr: mem_word(fl.pc)});
      end
    end
    if (redir) begin
      mq.delete();
      foreach (fq[k]) fq[k].stale = 1'b1;
      m_fpc = rpc & ~32'h3;
      m_flushes++;
    end else if (exp_rv && rrdy) begin
      fq.push_back('{pc: m_fpc, stale: 1'b0});
      m_fpc = m_fpc + 32'd4;
      m_fetched++;
    end

    if (obs_rv && rrdy) begin
      mr.addr = obs_addr;
      mr.due  = cyc + lat_base + ((lat_rand > 0) ? int'($urandom_range(0, lat_rand)) : 0);
      if (mr.due <= last_due) mr.due = last_due + 1;
      last_due = mr.due;
      memq.push_back(mr);
    end

    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    nrst      = 1'b0;
    redirect  = 1'b0;
    rsp_valid = 1'b0;
    req_ready = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_req_valid", req_valid, 0);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    nrst = 1'b1;
    model_clear();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        ordy;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(input logic r, input logic [31:0] p, input logic o,
                              input logic rv, input logic [31:0] a,
                              input logic ov, input logic [31:0] pc);
    vec_t v;
    v.redir = r; v.rpc = p; v.ordy = o;
    v.e_rv = rv; v.e_addr = a; v.e_ov = ov; v.e_pc = pc;
    return v;
  endfunction

  initial begin
    // Memory always ready, 1-cycle responses. Sequential stream, then the
    // core stalls (credit stops at 4), then resumes, then a redirect that
    // coincides with a response and a pop, then two consecutive redirects.
    tbl[0]  = mk(0, 32'h0,   1, 1, 32'h00,  0, 32'h0);
    tbl[1]  = mk(0, 32'h0,   1, 1, 32'h04,  0, 32'h0);
    tbl[2]  = mk(0, 32'h0,   1, 1, 32'h08,  1, 32'h00);
    tbl[3]  = mk(0, 32'h0,   1, 1, 32'h0C,  1, 32'h04);
    tbl[4]  = mk(0, 32'h0,   1, 1, 32'h10,  1, 32'h08);
    tbl[5]  = mk(0, 32'h0,   1, 1, 32'h14,  1, 32'h0C);
    tbl[6]  = mk(0, 32'h0,   0, 1, 32'h18,  1, 32'h10);
    tbl[7]  = mk(0, 32'h0,   0, 1, 32'h1C,  1, 32'h10);
    tbl[8]  = mk(0, 32'h0,   0, 0, 32'h0,   1, 32'h10);
    tbl[9]  = mk(0, 32'h0,   0, 0, 32'h0,   1, 32'h10);
    tbl[10] = mk(0, 32'h0,   1, 0, 32'h0,   1, 32'h10);
    tbl[11] = mk(0, 32'h0,   1, 1, 32'h20,  1, 32'h14);
    tbl[12] = mk(0, 32'h0,   1, 1, 32'h24,  1, 32'h18);
    tbl[13] = mk(0, 32'h0,   1, 1, 32'h28,  1, 32'h1C);
    tbl[14] = mk(0, 32'h0,   1, 1, 32'h2C,  1, 32'h20);
    tbl[15] = mk(1, 32'h103, 1, 0, 32'h0,   1, 32'h24);
    tbl[16] = mk(0, 32'h0,   1, 1, 32'h100, 0, 32'h0);
    tbl[17] = mk(0, 32'h0,   1, 1, 32'h104, 0, 32'h0);
    tbl[18] = mk(0, 32'h0,   1, 1, 32'h108, 1, 32'h100);
    tbl[19] = mk(1, 32'h40,  1, 0, 32'h0,   1, 32'h104);
    tbl[20] = mk(1, 32'h80,  1, 0, 32'h0,   0, 32'h0);
    tbl[21] = mk(0, 32'h0,   1, 1, 32'h80,  0, 32'h0);
    tbl[22] = mk(0, 32'h0,   1, 1, 32'h84,  0, 32'h0);
    tbl[23] = mk(0, 32'h0,   1, 1, 32'h88,  1, 32'h80);

    model_clear();
    lat_base = 1;
    lat_rand = 0;
    do_reset();

    for (int i = 0; i < 24; i++) begin
      step(tbl[i].redir, tbl[i].rpc, tbl[i].ordy, 1'b1);
      chk("tbl_req_valid", obs_rv, tbl[i].e_rv);
      if (tbl[i].e_rv) chk("tbl_req_addr", obs_addr, tbl[i].e_addr);
      chk("tbl_out_valid", obs_ov, tbl[i].e_ov);
      if (tbl[i].e_ov) begin
        chk("tbl_out_pc", obs_pc, tbl[i].e_pc);
        chk("tbl_out_instr", obs_instr, mem_word(tbl[i].e_pc));
      end
    end

    // Latency 3, two requests in flight, redirect to 0x100.
    do_reset();
    lat_base = 3;
    step(0, 32'h0, 1, 1);
    step(0, 32'h0, 1, 1);
    step(1, 32'h100, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 32'h0, 1, 1);
      chk("late_rsp_dropped", obs_ov, 0);
    end
    step(0, 32'h0, 1, 1);
    chk("redir_first_valid", obs_ov, 1);
    chk("redir_first_pc", obs_pc, 32'h100);
    chk("redir_first_instr", obs_instr, mem_word(32'h100));

    // Latency 3, three in flight, redirects on two consecutive cycles.
    do_reset();
    step(0, 32'h0, 1, 1);
    step(0, 32'h0, 1, 1);
    step(0, 32'h0, 1, 1);
    step(1, 32'h40, 1, 1);
    step(1, 32'h80, 1, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 32'h0, 1, 1);
      chk("dbl_redir_dropped", obs_ov, 0);
    end
    step(0, 32'h0, 1, 1);
    chk("dbl_redir_valid", obs_ov, 1);
    chk("dbl_redir_pc", obs_pc, 32'h80);
    chk("dbl_redir_instr", obs_instr, mem_word(32'h80));

    // Randomized traffic with a reset in the middle.
    do_reset();
    lat_base = 1;
    lat_rand = 3;
    for (int i = 0; i < 2500; i++) begin
      if (i == 1200) begin
        do_reset();
        step(0, 32'h0, 0, 0);
        chk("midrst_out_valid", obs_ov, 0);
        chk("midrst_req_addr", obs_addr, RESET_PC);
        chk("midrst_req_valid", obs_rv, 1);
`ifdef IFQ_STATS_EN
        chk("midrst_stat_fetched", stat_fetched, 0);
        chk("midrst_stat_flushes", stat_flushes, 0);
        chk("midrst_stat_dropped", stat_dropped, 0);
`endif
      end
      step(($urandom_range(0, 15) == 0), $urandom,
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
